// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and constants for the UART command frame controller.
//   state_t   - frame parser / commit FSM states
//   SYNC_BYTE - frame start marker
//   ERR_*     - err_code values reported on a dropped frame
package uart_cmd_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM, COMMIT} state_t;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [1:0] ERR_LEN   = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;
    localparam logic [1:0] ERR_TMO   = 2'd3;
endpackage

// File: rtl/uart_cmd_buf.sv
// uart_cmd_buf: MAX_LEN x 8 payload buffer, synchronous single-port write, asynchronous read.
//   clk   in       - clock
//   we    in       - write enable
//   waddr in  IW   - write index
//   wdata in  8    - write byte
//   raddr in  IW   - read index
//   rdata out 8    - byte at raddr (combinational)
// Contents are not reset; only indices written by the current frame are ever read.
module uart_cmd_buf
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int IW      = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [IW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses framed register-write commands from the UART byte stream and
// replays each accepted frame as a burst of valid/ready register writes.
//   clk, rst (sync, active-high)
//   rx_data/rx_valid in  - received byte and its one-cycle strobe
//   wr_en/wr_addr/wr_data out, wr_ready in - register write port
//   busy out       - not IDLE
//   frame_done out - pulse after the last write of a frame is accepted
//   frame_err out  - pulse when a frame is dropped, cause in err_code (held to next frame start)
//   rx_overrun out - pulse when a byte arrives during COMMIT (byte dropped)
// Build option: define UART_CMD_CHKSUM_EN to require and check a trailing XOR checksum byte;
// without it the frame ends after the last data byte and goes straight to COMMIT.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 4096,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              rx_overrun
);
    localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam int GW = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    MAX_B    = 8'(MAX_LEN);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [7:0]        len;
    logic [7:0]        idx;
    logic [GW-1:0]     gap;
    logic [7:0]        rd_data;
    logic [IW-1:0]     rd_idx;
    logic              gap_run;
    logic              last_byte;

    assign gap_run   = state inside {ADDR, LEN, DATA, CSUM};
    assign last_byte = idx == len - 8'd1;
    // Look one entry ahead in COMMIT so the next write's data is ready at the handshake edge.
    assign rd_idx    = state == COMMIT ? IW'(idx + 8'd1) : '0;

    uart_cmd_buf #(.MAX_LEN(MAX_LEN), .IW(IW)) u_buf (
        .clk   (clk),
        .we    (state == DATA && rx_valid),
        .waddr (IW'(idx)),
        .wdata (rx_data),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

`ifdef UART_CMD_CHKSUM_EN
    logic [7:0] acc;

    // Running XOR of ADDR, LEN and data; held at zero while idle so it starts clean in ADDR.
    always_ff @(posedge clk)
        acc <= rst || state == IDLE ? '0 : rx_valid && state inside {ADDR, LEN, DATA} ? acc ^ rx_data : acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= '0;
            rx_overrun <= 1'b0;
            gap        <= '0;
            base       <= '0;
            len        <= '0;
            idx        <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            rx_overrun <= 1'b0;
            gap        <= rx_valid || !gap_run ? '0 : gap + GW'(1);
            case (state)
                IDLE:
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state    <= ADDR;
                        busy     <= 1'b1;
                        err_code <= '0;
                        idx      <= '0;
                    end
                ADDR:
                    if (rx_valid) begin
                        state <= LEN;
                        base  <= ADDR_W'(rx_data);
                    end
                LEN:
                    if (rx_valid) begin
                        len <= rx_data;
                        if (rx_data == 8'd0 || rx_data > MAX_B) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                        end else
                            state <= DATA;
                    end
                DATA:
                    if (rx_valid) begin
                        idx <= last_byte ? '0 : idx + 8'd1;
                        if (last_byte) begin
`ifdef UART_CMD_CHKSUM_EN
                            state <= CSUM;
`else
                            state   <= COMMIT;
                            wr_en   <= 1'b1;
                            wr_addr <= base;
                            // A one-byte frame is being written this very edge, so bypass the buffer.
                            wr_data <= idx == 8'd0 ? rx_data : rd_data;
`endif
                        end
                    end
`ifdef UART_CMD_CHKSUM_EN
                CSUM:
                    if (rx_valid) begin
                        if (rx_data == acc) begin
                            state   <= COMMIT;
                            wr_en   <= 1'b1;
                            wr_addr <= base;
                            wr_data <= rd_data;
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                            err_code  <= ERR_CSUM;
                        end
                    end
`endif
                COMMIT: begin
                    rx_overrun <= rx_valid;
                    if (wr_ready) begin
                        if (last_byte) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            wr_en      <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            idx     <= idx + 8'd1;
                            wr_addr <= wr_addr + ADDR_W'(1);
                            wr_data <= rd_data;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    wr_en <= 1'b0;
                end
            endcase
            // Inter-byte stall: overrides whatever the parser decided this edge.
            if (gap_run && !rx_valid && gap == GAP_LAST) begin
                state     <= IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
                err_code  <= ERR_TMO;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed self-checking bench for uart_cmd_ctrl (default parameters).
module tb_uart_cmd_ctrl;
    localparam int TIMEOUT = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       wr_ready = 1'b1;
    logic       wr_en, busy, frame_done, frame_err, rx_overrun;
    logic [7:0] wr_addr, wr_data;
    logic [1:0] err_code;

    int n_vec = 0, n_bad = 0, cyc = 0;
    int n_done = 0, n_wren = 0, n_moved = 0;
    logic [7:0] wa[$], wd[$], fr[$];
    int wc[$];
    logic hold_q = 1'b0;
    logic [15:0] held = '0;

    always #5 clk = ~clk;

    uart_cmd_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .rx_overrun (rx_overrun)
    );

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (wr_en && wr_ready) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
            wc.push_back(cyc);
        end
        if (hold_q && wr_en && {wr_addr, wr_data} != held) n_moved++;
        hold_q = wr_en && !wr_ready;
        held   = {wr_addr, wr_data};
        if (frame_done) n_done++;
        if (wr_en) n_wren++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_raw();
        foreach (fr[i]) send(fr[i]);
    endtask

    // Sends the bytes after the sync byte, appending the XOR checksum when the build has one.
    task automatic send_frame();
`ifdef UART_CMD_CHKSUM_EN
        begin
            logic [7:0] c;
            c = 8'h00;
            foreach (fr[i]) c ^= fr[i];
            fr.push_back(c);
        end
`endif
        send_raw();
    endtask

    task automatic wait_done();
        int d0;
        d0 = n_done;
        for (int i = 0; i < 20 && n_done == d0; i++) tick(1);
        check("done_pulse", n_done - d0, 1);
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    initial begin
        tick(2);
        check("rst_ctl", {wr_en, busy, frame_done, frame_err, rx_overrun}, 5'b0);
        check("rst_addr", wr_addr, 8'h00);
        check("rst_data", wr_data, 8'h00);
        check("rst_err", err_code, 2'd0);
        rst = 1'b0;
        tick(1);

        send(8'h55);
        send(8'h10);
        check("idle_ignore", busy, 1'b0);

        // Good three-byte frame at 0x10.
        clear_log();
        send(8'hA5);
        check("sync_busy", busy, 1'b1);
        fr = '{8'h10, 8'h03, 8'h11, 8'h22, 8'h33};
        send_frame();
        check("good_entry", {wr_en, wr_addr, wr_data}, {1'b1, 8'h10, 8'h11});
        wait_done();
        check("good_cnt", wa.size(), 3);
        check("good_w0", {wa[0], wd[0]}, 16'h1011);
        check("good_w1", {wa[1], wd[1]}, 16'h1122);
        check("good_w2", {wa[2], wd[2]}, 16'h1233);
        check("good_back2back", wc[2] - wc[0], 2);
        check("good_idle", {busy, wr_en}, 2'b00);

`ifdef UART_CMD_CHKSUM_EN
        begin
            int w0;
            w0 = n_wren;
            send(8'hA5);
            fr = '{8'h10, 8'h01, 8'h55, 8'h00};
            send_raw();
            check("csum_err", {frame_err, err_code, busy}, {1'b1, 2'd2, 1'b0});
            tick(3);
            check("csum_no_wr", n_wren - w0, 0);
        end
`endif

        // Length errors, then a clean frame.
        send(8'hA5);
        fr = '{8'h10, 8'h00};
        send_raw();
        check("len0_err", {frame_err, err_code, busy}, {1'b1, 2'd1, 1'b0});
        tick(1);
        check("len0_pulse", frame_err, 1'b0);
        send(8'hA5);
        check("err_clear", err_code, 2'd0);
        fr = '{8'h10, 8'h11};
        send_raw();
        check("len17_err", {frame_err, err_code, busy}, {1'b1, 2'd1, 1'b0});
        clear_log();
        send(8'hA5);
        fr = '{8'h30, 8'h01, 8'h7E};
        send_frame();
        wait_done();
        check("after_err_wr", {wa.size() == 1, wa[0], wd[0]}, {1'b1, 8'h30, 8'h7E});

        // Sync byte inside the payload is plain data.
        clear_log();
        send(8'hA5);
        fr = '{8'h20, 8'h02, 8'hA5, 8'hA5};
        send_frame();
        wait_done();
        check("a5_data_cnt", wa.size(), 2);
        check("a5_data_w1", {wa[1], wd[1]}, 16'h21A5);

        // Stall mid-frame.
        send(8'hA5);
        fr = '{8'h00, 8'h02, 8'hAA};
`ifdef UART_CMD_CHKSUM_EN
        fr.push_back(8'hBB);
`endif
        send_raw();
        tick(TIMEOUT - 1);
        check("stall_wait", {busy, frame_err}, 2'b10);
        tick(1);
        check("stall_tmo", {frame_err, err_code, busy}, {1'b1, 2'd3, 1'b0});

        // Backpressure, address wrap and overrun.
        clear_log();
        wr_ready = 1'b0;
        send(8'hA5);
        fr = '{8'hFF, 8'h02, 8'hC1, 8'hC2};
        send_frame();
        check("bp_entry", {wr_en, wr_addr, wr_data}, {1'b1, 8'hFF, 8'hC1});
        send(8'hA5);
        check("bp_overrun", {rx_overrun, wr_addr, wr_data}, {1'b1, 8'hFF, 8'hC1});
        tick(1);
        check("bp_hold", {rx_overrun, wr_en, wr_addr, wr_data}, {1'b0, 1'b1, 8'hFF, 8'hC1});
        wr_ready = 1'b1;
        tick(1);
        check("bp_wrap", {wr_en, wr_addr, wr_data}, {1'b1, 8'h00, 8'hC2});
        wr_ready = 1'b0;
        tick(1);
        check("bp_hold2", {wr_en, wr_addr, wr_data}, {1'b1, 8'h00, 8'hC2});
        wr_ready = 1'b1;
        tick(1);
        check("bp_done", {wr_en, frame_done}, 2'b01);
        tick(2);
        check("bp_no_resync", busy, 1'b0);
        check("bp_log", {wa.size() == 2, wa[0], wd[0], wa[1], wd[1]}, {1'b1, 32'hFFC1_00C2});
        check("bp_stable", n_moved, 0);

        // Reset in the middle of a commit.
        clear_log();
        wr_ready = 1'b0;
        send(8'hA5);
        fr = '{8'h40, 8'h02, 8'h01, 8'h02};
        send_frame();
        check("rc_entry", wr_en, 1'b1);
        rst = 1'b1;
        tick(1);
        check("rc_ctl", {wr_en, busy, frame_done, frame_err, rx_overrun, err_code}, 7'b0);
        check("rc_bus", {wr_addr, wr_data}, 16'h0000);
        rst = 1'b0;
        wr_ready = 1'b1;
        tick(3);
        check("rc_quiet", {wr_en, busy}, 2'b00);
        check("rc_no_wr", wa.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
